// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - per-channel PLL reset/lock supervisor with retry and fault; lock-loss counters enabled by PLL_SUP_LOSS_CNT_EN
module pll_lock_supervisor #(
    parameter int NUM_PLLS      = 2,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PLLS-1:0]       locked,
    input  logic [NUM_PLLS-1:0]       restart,
    input  logic [NUM_PLLS-1:0]       clear_fault,
    output logic [NUM_PLLS-1:0]       pll_rst,
    output logic [NUM_PLLS-1:0]       ready,
    output logic [NUM_PLLS-1:0]       fault,
    output logic [NUM_PLLS*CNT_W-1:0] lock_loss_cnt
);

    // One shared per-channel cycle counter covers the longest of the three timed phases
    localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CNT = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int RW      = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_READY,
        S_FAULT
    } state_t;

    for (genvar i = 0; i < NUM_PLLS; i++) begin : g_ch
        logic          sync1;
        logic          lk_s;
        state_t        state;
        logic [CW-1:0] cnt;
        logic [RW-1:0] rty;
        logic          pll_rst_q;
        logic          ready_q;
        logic          fault_q;

        // Two-flop synchroniser bringing the asynchronous lock indication into clk
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1 <= 1'b0;
                lk_s  <= 1'b0;
            end else begin
                sync1 <= locked[i];
                lk_s  <= sync1;
            end
        end

        // Channel sequencer; restart overrides every transition, outputs registered with the state
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state     <= S_RESET;
                cnt       <= '0;
                rty       <= '0;
                pll_rst_q <= 1'b1;
                ready_q   <= 1'b0;
                fault_q   <= 1'b0;
            end else if (restart[i]) begin
                state     <= S_RESET;
                cnt       <= '0;
                rty       <= '0;
                pll_rst_q <= 1'b1;
                ready_q   <= 1'b0;
                fault_q   <= 1'b0;
            end else begin
                case (state)
                    S_RESET: begin
                        if (cnt == CW'(RST_CYCLES - 1)) begin
                            state     <= S_WAIT_LOCK;
                            cnt       <= '0;
                            pll_rst_q <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_WAIT_LOCK: begin
                        if (lk_s) begin
                            state <= S_STABLE;
                            cnt   <= '0;
                        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                            cnt       <= '0;
                            pll_rst_q <= 1'b1;
                            if (rty == RW'(MAX_RETRIES)) begin
                                state   <= S_FAULT;
                                fault_q <= 1'b1;
                            end else begin
                                state <= S_RESET;
                                rty   <= rty + RW'(1);
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_STABLE: begin
                        if (!lk_s) begin
                            state <= S_WAIT_LOCK;
                            cnt   <= '0;
                        end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                            state   <= S_READY;
                            cnt     <= '0;
                            ready_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_READY: begin
                        if (!lk_s) begin
                            state     <= S_RESET;
                            cnt       <= '0;
                            rty       <= '0;
                            ready_q   <= 1'b0;
                            pll_rst_q <= 1'b1;
                        end
                    end
                    S_FAULT: begin
                        if (clear_fault[i]) begin
                            state   <= S_RESET;
                            cnt     <= '0;
                            rty     <= '0;
                            fault_q <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= S_RESET;
                        cnt       <= '0;
                        rty       <= '0;
                        pll_rst_q <= 1'b1;
                        ready_q   <= 1'b0;
                        fault_q   <= 1'b0;
                    end
                endcase
            end
        end

        assign pll_rst[i] = pll_rst_q;
        assign ready[i]   = ready_q;
        assign fault[i]   = fault_q;

`ifdef PLL_SUP_LOSS_CNT_EN
        logic [CNT_W-1:0] llc;
        logic             loss_evt;

        // A loss only counts when READY actually drops out; a simultaneous restart suppresses it
        assign loss_evt = (state == S_READY) && !lk_s && !restart[i];

        // Saturating lock-loss event counter
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                llc <= '0;
            end else if (loss_evt && (llc != {CNT_W{1'b1}})) begin
                llc <= llc + CNT_W'(1);
            end
        end

        assign lock_loss_cnt[i*CNT_W +: CNT_W] = llc;
`else
        assign lock_loss_cnt[i*CNT_W +: CNT_W] = '0;
`endif
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - scoreboard bench for pll_lock_supervisor
module tb_pll_lock_supervisor;

    localparam int NUM_PLLS      = 2;
    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;
    localparam int CNT_W         = 8;
    localparam int LLC_MAX       = (1 << CNT_W) - 1;
`ifdef PLL_SUP_LOSS_CNT_EN
    localparam bit LLC_EN = 1'b1;
`else
    localparam bit LLC_EN = 1'b0;
`endif
    localparam logic [10:0] RST_VAL = 11'h400;

    localparam int M_RST  = 0;
    localparam int M_WAIT = 1;
    localparam int M_STB  = 2;
    localparam int M_RDY  = 3;
    localparam int M_FLT  = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_PLLS-1:0]       locked;
    logic [NUM_PLLS-1:0]       restart;
    logic [NUM_PLLS-1:0]       clear_fault;
    logic [NUM_PLLS-1:0]       pll_rst;
    logic [NUM_PLLS-1:0]       ready;
    logic [NUM_PLLS-1:0]       fault;
    logic [NUM_PLLS*CNT_W-1:0] lock_loss_cnt;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .NUM_PLLS(NUM_PLLS), .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES), .MAX_RETRIES(MAX_RETRIES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .locked(locked), .restart(restart), .clear_fault(clear_fault),
        .pll_rst(pll_rst), .ready(ready), .fault(fault), .lock_loss_cnt(lock_loss_cnt)
    );

    typedef struct {
        int          cyc;
        logic [10:0] val;
    } ev_t;

    ev_t         exp_q [NUM_PLLS][$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    bit          mon_en      = 1'b0;
    logic [10:0] seen   [NUM_PLLS];
    logic [10:0] last_m [NUM_PLLS] = '{default: RST_VAL};

    // Reference model: phase plus absolute deadline cycle per channel
    int   mode_m [NUM_PLLS] = '{default: M_RST};
    int   dl_m   [NUM_PLLS] = '{default: RST_CYCLES};
    int   rty_m  [NUM_PLLS] = '{default: 0};
    int   llc_m  [NUM_PLLS] = '{default: 0};
    logic s1_m   [NUM_PLLS] = '{default: 1'b0};
    logic s2_m   [NUM_PLLS] = '{default: 1'b0};

    function automatic logic [10:0] m_val(int ch);
        logic [7:0] l;
        l = LLC_EN ? 8'(llc_m[ch]) : 8'd0;
        return {(mode_m[ch] == M_RST) || (mode_m[ch] == M_FLT), mode_m[ch] == M_RDY,
                mode_m[ch] == M_FLT, l};
    endfunction

    task automatic note_change(int ch);
        ev_t         e;
        logic [10:0] v;
        v = m_val(ch);
        if (v != last_m[ch]) begin
            e.cyc = cyc;
            e.val = v;
            exp_q[ch].push_back(e);
            last_m[ch] = v;
        end
    endtask

    task automatic model_reset_ch(int ch);
        mode_m[ch] = M_RST;
        dl_m[ch]   = cyc + RST_CYCLES;
        rty_m[ch]  = 0;
        llc_m[ch]  = 0;
        s1_m[ch]   = 1'b0;
        s2_m[ch]   = 1'b0;
        note_change(ch);
    endtask

    task automatic model_step();
        for (int ch = 0; ch < NUM_PLLS; ch++) begin
            logic lk;
            if (rst) begin
                model_reset_ch(ch);
                continue;
            end
            lk = s2_m[ch];
            s2_m[ch] = s1_m[ch];
            s1_m[ch] = locked[ch];
            if (restart[ch]) begin
                mode_m[ch] = M_RST;
                dl_m[ch]   = cyc + RST_CYCLES;
                rty_m[ch]  = 0;
            end else begin
                case (mode_m[ch])
                    M_RST: if (cyc == dl_m[ch]) begin
                        mode_m[ch] = M_WAIT;
                        dl_m[ch]   = cyc + LOCK_TIMEOUT;
                    end
                    M_WAIT: if (lk) begin
                        mode_m[ch] = M_STB;
                        dl_m[ch]   = cyc + STABLE_CYCLES;
                    end else if (cyc == dl_m[ch]) begin
                        if (rty_m[ch] == MAX_RETRIES) begin
                            mode_m[ch] = M_FLT;
                        end else begin
                            rty_m[ch]++;
                            mode_m[ch] = M_RST;
                            dl_m[ch]   = cyc + RST_CYCLES;
                        end
                    end
                    M_STB: if (!lk) begin
                        mode_m[ch] = M_WAIT;
                        dl_m[ch]   = cyc + LOCK_TIMEOUT;
                    end else if (cyc == dl_m[ch]) begin
                        mode_m[ch] = M_RDY;
                    end
                    M_RDY: if (!lk) begin
                        if (llc_m[ch] < LLC_MAX) llc_m[ch]++;
                        rty_m[ch]  = 0;
                        mode_m[ch] = M_RST;
                        dl_m[ch]   = cyc + RST_CYCLES;
                    end
                    default: if (clear_fault[ch]) begin
                        rty_m[ch]  = 0;
                        mode_m[ch] = M_RST;
                        dl_m[ch]   = cyc + RST_CYCLES;
                    end
                endcase
            end
            note_change(ch);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        model_step();
    end

    always @(posedge rst) begin
        for (int ch = 0; ch < NUM_PLLS; ch++) model_reset_ch(ch);
    end

    // Monitor: every change of a channel's outputs must match the next predicted event
    always @(negedge clk) begin
        if (mon_en) begin
            for (int ch = 0; ch < NUM_PLLS; ch++) begin
                logic [10:0] cur;
                ev_t         e;
                cur = {pll_rst[ch], ready[ch], fault[ch], lock_loss_cnt[ch*CNT_W +: CNT_W]};
                if (cur !== seen[ch]) begin
                    seen[ch] = cur;
                    vectors++;
                    if (exp_q[ch].size() == 0) begin
                        miscompares++;
                        $display("FAIL sb_ch%0d: output change at cycle %0d got %h, required no change",
                                 ch, cyc, cur);
                    end else begin
                        e = exp_q[ch].pop_front();
                        if (e.cyc != cyc || e.val !== cur) begin
                            miscompares++;
                            $display("FAIL sb_ch%0d: got %h at cycle %0d, required %h at cycle %0d",
                                     ch, cur, cyc, e.val, e.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_ready(input int ch, input int budget);
        int k;
        k = 0;
        while (ready[ch] !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("wait_ready_ch%0d", ch), 32'(ready[ch]), 32'd1);
    endtask

    initial begin
        int  c0;
        int  d;
        ev_t e;
        rst         = 1'b1;
        locked      = '0;
        restart     = '0;
        clear_fault = '0;
        for (int ch = 0; ch < NUM_PLLS; ch++) seen[ch] = RST_VAL;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        chk("reset_pll_rst", 32'(pll_rst), 32'h3);
        chk("reset_ready", 32'(ready), 32'h0);
        chk("reset_fault", 32'(fault), 32'h0);
        chk("reset_llc", 32'(lock_loss_cnt), 32'h0);

        // Normal lock on ch0 while ch1 never locks
        rst = 1'b0;
        c0  = cyc;
        wait_cyc(c0 + 3);  chk("pll_rst0_pulse_hi", 32'(pll_rst[0]), 32'd1);
        wait_cyc(c0 + 4);  chk("pll_rst0_pulse_lo", 32'(pll_rst[0]), 32'd0);
        wait_cyc(c0 + 10); locked[0] = 1'b1;
        wait_cyc(c0 + 20); chk("ready0_early", 32'(ready[0]), 32'd0);
        wait_cyc(c0 + 21); chk("ready0_at_11", 32'(ready[0]), 32'd1);
        chk("fault0_clear", 32'(fault[0]), 32'd0);

        // Lock loss in READY
        wait_cyc(c0 + 25); locked[0] = 1'b0;
        wait_cyc(c0 + 27); chk("ready0_hold", 32'(ready[0]), 32'd1);
        wait_cyc(c0 + 28); chk("ready0_fall_3", 32'(ready[0]), 32'd0);
        chk("llc0_first_loss", 32'(lock_loss_cnt[7:0]), LLC_EN ? 32'd1 : 32'd0);
        chk("pll_rst0_after_loss", 32'(pll_rst[0]), 32'd1);
        wait_cyc(c0 + 31); chk("pll_rst0_loss_hi", 32'(pll_rst[0]), 32'd1);
        wait_cyc(c0 + 32); chk("pll_rst0_loss_lo", 32'(pll_rst[0]), 32'd0);
        wait_cyc(c0 + 33); locked[0] = 1'b1;
        wait_cyc(c0 + 35); chk("pll_rst1_gap", 32'(pll_rst[1]), 32'd0);
        wait_cyc(c0 + 36); chk("pll_rst1_retry1", 32'(pll_rst[1]), 32'd1);
        // Glitch during STABLE
        wait_cyc(c0 + 39); locked[0] = 1'b0;
        chk("pll_rst1_retry1_hi", 32'(pll_rst[1]), 32'd1);
        wait_cyc(c0 + 40); chk("pll_rst1_retry1_lo", 32'(pll_rst[1]), 32'd0);
        wait_cyc(c0 + 42); locked[0] = 1'b1;
        wait_cyc(c0 + 52); chk("ready0_glitch_early", 32'(ready[0]), 32'd0);
        wait_cyc(c0 + 53); chk("ready0_glitch_11", 32'(ready[0]), 32'd1);
        chk("llc0_glitch_nocount", 32'(lock_loss_cnt[7:0]), LLC_EN ? 32'd1 : 32'd0);

        // Timeout to fault on ch1, then clear
        wait_cyc(c0 + 107); chk("fault1_early", 32'(fault[1]), 32'd0);
        wait_cyc(c0 + 108); chk("fault1_at_108", 32'(fault[1]), 32'd1);
        chk("pll_rst1_fault_held", 32'(pll_rst[1]), 32'd1);
        wait_cyc(c0 + 112); clear_fault[1] = 1'b1;
        wait_cyc(c0 + 113); clear_fault[1] = 1'b0; locked[1] = 1'b1;
        chk("fault1_cleared", 32'(fault[1]), 32'd0);
        chk("pll_rst1_after_clear", 32'(pll_rst[1]), 32'd1);
        wait_ready(1, 40);

        // Independence: restart ch1 only
        restart[1] = 1'b1;
        @(negedge clk);
        restart[1] = 1'b0;
        chk("restart1_ready", 32'(ready[1]), 32'd0);
        chk("restart1_pll_rst", 32'(pll_rst[1]), 32'd1);
        chk("restart1_ch0_ready", 32'(ready[0]), 32'd1);
        chk("restart1_ch0_llc", 32'(lock_loss_cnt[7:0]), LLC_EN ? 32'd1 : 32'd0);
        wait_ready(1, 40);
        chk("restart1_ch0_still", 32'(ready[0]), 32'd1);

        // Repeated lock loss until the counter saturates
        for (int i = 0; i < 300; i++) begin
            locked[0] = 1'b0;
            repeat (5) @(negedge clk);
            locked[0] = 1'b1;
            wait_ready(0, 40);
            if (i == 9) chk("llc0_after_10", 32'(lock_loss_cnt[7:0]), LLC_EN ? 32'd11 : 32'd0);
        end
        chk("llc0_saturated", 32'(lock_loss_cnt[7:0]), LLC_EN ? 32'd255 : 32'd0);

        // Randomised lock waveforms, restarts and fault clears
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(23, 0) == 0) locked[0] = ~locked[0];
            if ($urandom_range(79, 0) == 0) locked[1] = ~locked[1];
            restart     = {($urandom_range(127, 0) == 0), ($urandom_range(127, 0) == 0)};
            clear_fault = {($urandom_range(15, 0) == 0), ($urandom_range(15, 0) == 0)};
            @(negedge clk);
        end
        restart     = '0;
        clear_fault = '0;

        // Asynchronous reset while both channels wait for lock
        locked  = '0;
        restart = 2'b11;
        @(negedge clk);
        restart = '0;
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_pll_rst", 32'(pll_rst), 32'h3);
        chk("async_ready", 32'(ready), 32'h0);
        chk("async_fault", 32'(fault), 32'h0);
        chk("async_llc", 32'(lock_loss_cnt), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        d   = cyc;
        wait_cyc(d + 3); chk("rerst_pll_rst_hi", 32'(pll_rst), 32'h3);
        wait_cyc(d + 4); chk("rerst_pll_rst_lo", 32'(pll_rst), 32'h0);

        repeat (5) @(negedge clk);
        for (int ch = 0; ch < NUM_PLLS; ch++) begin
            while (exp_q[ch].size() != 0) begin
                e = exp_q[ch].pop_front();
                vectors++;
                miscompares++;
                $display("FAIL sb_ch%0d_missing: got no change, required %h at cycle %0d",
                         ch, e.val, e.cyc);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Parametrised reset-and-lock supervisor for NUM_PLLS independent PLL instances, such as the core/reconfigurable PLL wrappers. For each PLL it pulses the PLL reset, waits for `locked` with a timeout, and qualifies lock over a stable window before asserting `ready`. It also retries failed lock attempts up to a limit, then latches a fault. It sits between the top-level reset tree and the PLL wrappers and gates downstream clock-domain resets.

## Interface
- NUM_PLLS, 2, number of supervised PLLs (channels); 1..8
- RST_CYCLES, 16, PLL reset pulse length in `clk` cycles; ≥1
- LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK per attempt; ≥2
- STABLE_CYCLES, 256, cycles `locked` must stay high before `ready`; ≥1
- MAX_RETRIES, 4, retries after the first attempt before FAULT; ≥0
- CNT_W, 8, width of each lock-loss counter
- clk  in  1  free-running supervisor clock, independent of the PLL outputs
- rst  in  1  asynchronous, active-high reset
- locked  in  NUM_PLLS  PLL lock indications, asynchronous to `clk`
- restart  in  NUM_PLLS  per-channel restart request, one-cycle pulse, synchronous
- clear_fault  in  NUM_PLLS  per-channel fault clear, one-cycle pulse, synchronous
- pll_rst  out  NUM_PLLS  reset to each PLL `rst` port, active-high
- ready  out  NUM_PLLS  lock qualified; downstream may leave reset
- fault  out  NUM_PLLS  retries exhausted
- lock_loss_cnt  out  NUM_PLLS*CNT_W  per-channel saturating count of READY→lock-loss events; channel i occupies bits [i*CNT_W +: CNT_W]

## Operation
- Each channel has an identical, fully independent FSM (generate loop).
- Each channel has a 2-flop synchroniser on `locked[i]`, producing `lk_s`.
- Each channel has one shared cycle counter `cnt`, wide enough for the maximum of RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES.
- Each channel has a retry counter `rty`, range 0..MAX_RETRIES.
- FSM states and transitions:
  - RESET: `pll_rst`=1. When `cnt`==RST_CYCLES-1, go to WAIT_LOCK with `cnt`=0.
  - WAIT_LOCK: `pll_rst`=0.
    - If `lk_s`, go to STABLE with `cnt`=0.
    - Else if `cnt`==LOCK_TIMEOUT-1:
      - If `rty`==MAX_RETRIES, go to FAULT.
      - Otherwise increment `rty` and go to RESET with `cnt`=0.
  - STABLE:
    - If !`lk_s`, go to WAIT_LOCK with `cnt`=0. `rty` is unchanged and no loss is counted.
    - Else if `cnt`==STABLE_CYCLES-1, go to READY.
  - READY: `ready`=1. If !`lk_s`, increment `lock_loss_cnt` (saturating at 2^CNT_W-1), clear `rty`, and go to RESET with `cnt`=0.
  - FAULT: `fault`=1 and `pll_rst`=1 (held). On `clear_fault`, clear `rty` and go to RESET. `clear_fault` is ignored in every other state.
- `restart[i]` takes priority over every transition: from any state it goes to RESET with `cnt`=0 and `rty`=0. `lock_loss_cnt` is unchanged.
- If `restart` and `clear_fault` arrive in the same cycle, `restart` wins; the outcome is identical.
- All outputs are registered decodes of the state register.

## Timing
- Reset values: state RESET, `cnt`=0, `rty`=0, `pll_rst`=all 1, `ready`=0, `fault`=0, `lock_loss_cnt`=0, synchroniser flops 0.
- `rst` assertion mid-operation returns all channels to these values immediately, without waiting for a clock.
- After `rst` deasserts, `pll_rst` stays high for exactly RST_CYCLES rising edges.
- `locked`→`lk_s` latency is 2 cycles.
- `ready` rises STABLE_CYCLES+3 cycles after `locked` rises, provided `locked` stays high.
- `ready` falls 3 cycles after `locked` falls.
- Failed attempt period is RST_CYCLES+LOCK_TIMEOUT cycles. `fault` rises after (MAX_RETRIES+1) full attempt periods.
- `restart` takes effect on the next edge: `pll_rst` is high the following cycle and `ready` drops in the same cycle.

## Configuration
- PLL_SUP_LOSS_CNT_EN
  - Defined: `lock_loss_cnt` is implemented as specified.
  - Undefined: the counters are removed and `lock_loss_cnt` is tied to 0. All other behaviour is identical.

## Test plan
Bench parameters: NUM_PLLS=2, RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.
- Normal lock: release `rst`, then raise `locked[0]` 10 cycles later → `pll_rst[0]` high for 4 cycles; `ready[0]` rises exactly 11 cycles after `locked[0]`; `fault`=0.
- Glitch during STABLE: drop `locked[0]` for 3 cycles at STABLE count 5 → no `ready`; `lock_loss_cnt[0]` stays 0; `ready` rises 11 cycles after `locked` returns high.
- Timeout: hold `locked[1]`=0 → 3 `pll_rst[1]` pulses of 4 cycles, spaced 36 cycles apart; `fault[1]`=1 at cycle 108 with `pll_rst[1]` held high; `clear_fault[1]` restarts the sequence.
- Lock loss in READY: drop `locked[0]` → `ready[0]` falls 3 cycles later; `lock_loss_cnt[0]` goes 0→1; a 4-cycle `pll_rst[0]` pulse follows. Repeat 300 times with CNT_W=8 → the count saturates at 255.
- Independence: pulse `restart[1]` with both channels READY → only channel 1 re-sequences; channel 0 `ready` stays high and its counter is unchanged.
- Asynchronous reset: assert `rst` mid-WAIT_LOCK between clock edges → all outputs reach their reset values before the next edge.
- Macro-off build: repeat the lock-loss scenario with PLL_SUP_LOSS_CNT_EN undefined → `lock_loss_cnt` stays 0.
